// File: rtl/sub_nnbit_nibble_serial.sv
// rtl/sub_nnbit_nibble_serial.sv - nibble-serial subtractor a - b - brw with valid/ready handshakes
module sub_nnbit_nibble_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_brw,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_brw,
    output logic                  o_ovf
);

    localparam int N  = DATA_WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4) begin : g_bad_width
            $error("sub_nnbit_nibble_serial: DATA_WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic                    brw_reg;
    logic [DATA_WIDTH-1:0]   a_sh;
    logic [DATA_WIDTH-1:0]   b_sh;
    logic                    a_msb;
    logic                    b_msb;
    logic [DATA_WIDTH-1:0]   partial;
    logic [DATA_WIDTH-1:0]   partial_nxt;
    logic [4:0]              nib_sum;
    logic                    last_nib;

    // Operands shift right so the active nibble is always at [3:0]; results enter at the top.
    assign nib_sum  = {1'b0, a_sh[3:0]} + {1'b0, ~b_sh[3:0]} + {4'b0000, ~brw_reg};
    assign last_nib = (cnt == CW'(N - 1));

    always_comb begin
        partial_nxt = partial >> 4;
        partial_nxt[DATA_WIDTH-4 +: 4] = nib_sum[3:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_valid) state_nxt = S_CALC;
            S_CALC: if (last_nib) state_nxt = S_DONE;
            S_DONE: if (i_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_ready = (state == S_IDLE) & i_rst_n;
    assign o_valid = (state == S_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            brw_reg <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            partial <= '0;
            o_res   <= '0;
            o_brw   <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_sh    <= i_num_a;
                        b_sh    <= i_num_b;
                        a_msb   <= i_num_a[DATA_WIDTH-1];
                        b_msb   <= i_num_b[DATA_WIDTH-1];
                        brw_reg <= i_brw;
                        cnt     <= '0;
                    end
                end
                S_CALC: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    partial <= partial_nxt;
                    brw_reg <= ~nib_sum[4];
                    cnt     <= cnt + 1'b1;
                    if (last_nib) begin
                        o_res <= partial_nxt;
                        o_brw <= ~nib_sum[4];
                        o_ovf <= (a_msb != b_msb) & (partial_nxt[DATA_WIDTH-1] != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_nnbit_nibble_serial.sv
// tb/tb_sub_nnbit_nibble_serial.sv - randomized self-checking bench for sub_nnbit_nibble_serial at 8 and 16 bits
module tb_sub_nnbit_nibble_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v8, v16;
    logic [15:0] a_in, b_in;
    logic        brw_in;
    logic        rdy_in;

    logic        r8, ov8, bo8, of8;
    logic [7:0]  res8;
    logic        r16, ov16, bo16, of16;
    logic [15:0] res16;

    int          cur_w;
    logic        sel_ready, sel_valid, sel_bo, sel_of;
    logic [15:0] sel_res;

    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    sub_nnbit_nibble_serial #(.DATA_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(r8),
        .i_num_a(a_in[7:0]), .i_num_b(b_in[7:0]), .i_brw(brw_in),
        .o_valid(ov8), .i_ready(rdy_in), .o_res(res8), .o_brw(bo8), .o_ovf(of8)
    );

    sub_nnbit_nibble_serial #(.DATA_WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16), .o_ready(r16),
        .i_num_a(a_in), .i_num_b(b_in), .i_brw(brw_in),
        .o_valid(ov16), .i_ready(rdy_in), .o_res(res16), .o_brw(bo16), .o_ovf(of16)
    );

    always_comb begin
        sel_ready = r8;
        sel_valid = ov8;
        sel_res   = {8'h00, res8};
        sel_bo    = bo8;
        sel_of    = of8;
        if (cur_w == 16) begin
            sel_ready = r16;
            sel_valid = ov16;
            sel_res   = res16;
            sel_bo    = bo16;
            sel_of    = of16;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (w=%0d): got %0h, expected %0h", tag, cur_w, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed interpretations.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output logic [15:0] r, output logic bo, output logic of);
        int full, half, ua, ub, sa, sb, diff, sdiff;
        full  = 1 << w;
        half  = full / 2;
        ua    = int'(a) % full;
        ub    = int'(b) % full;
        diff  = ua - ub - int'(bi);
        r     = 16'((diff + full) % full);
        bo    = (diff < 0);
        sa    = (ua >= half) ? ua - full : ua;
        sb    = (ub >= half) ? ub - full : ub;
        sdiff = sa - sb - int'(bi);
        of    = (sdiff < -half) || (sdiff >= half);
    endtask

    task automatic set_valid(input int w, input logic v);
        if (w == 16) v16 = v;
        else         v8  = v;
    endtask

    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input int hold, output logic [15:0] r_o, output logic bo_o, output logic of_o);
        logic [15:0] er, r_before;
        logic        ebo, eof;
        int          cyc;
        cur_w = w;
        model(w, a, b, bi, er, ebo, eof);
        #1;
        check("ready_idle", 32'(sel_ready), 32'd1);
        r_before = sel_res;
        a_in = a; b_in = b; brw_in = bi;
        set_valid(w, 1'b1);
        @(posedge clk); #1;
        set_valid(w, 1'b0);
        a_in = 16'($urandom); b_in = 16'($urandom); brw_in = 1'($urandom);
        check("ready_calc", 32'(sel_ready), 32'd0);
        cyc = 0;
        while (!sel_valid && cyc < 20) begin
            check("res_hold_calc", 32'(sel_res), 32'(r_before));
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, w / 4);
        check("res", 32'(sel_res), 32'(er));
        check("brw_out", 32'(sel_bo), 32'(ebo));
        check("ovf", 32'(sel_of), 32'(eof));
        r_o = sel_res; bo_o = sel_bo; of_o = sel_of;
        for (int i = 0; i < hold; i++) begin
            set_valid(w, 1'b1);
            @(posedge clk); #1;
            check("bp_valid", 32'(sel_valid), 32'd1);
            check("bp_ready", 32'(sel_ready), 32'd0);
            check("bp_res", 32'(sel_res), 32'(er));
        end
        set_valid(w, 1'b0);
        rdy_in = 1'b1;
        @(posedge clk); #1;
        rdy_in = 1'b0;
        check("hs_valid_drop", 32'(sel_valid), 32'd0);
        check("hs_ready", 32'(sel_ready), 32'd1);
        check("hs_res_hold", 32'(sel_res), 32'(er));
    endtask

    logic [15:0] r;
    logic        bo, of;

    initial begin
        rst_n = 1'b0; v8 = 1'b0; v16 = 1'b0; rdy_in = 1'b0;
        a_in = '0; b_in = '0; brw_in = 1'b0; cur_w = 8;
        #1;
        check("rst_ready8", 32'(r8), 32'd0);
        check("rst_ready16", 32'(r16), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(r8 & r16), 32'd1);
        check("post_rst_valid", 32'(ov8 | ov16), 32'd0);
        check("post_rst_res", 32'({res8, res16}), 32'd0);
        check("post_rst_flags", 32'({bo8, of8, bo16, of16}), 32'd0);
        @(posedge clk); #1;

        run_op(8, 16'h0035, 16'h0012, 1'b0, 5, r, bo, of);
        check("d35_12", 32'({of, bo, r}), 32'h0_0023);
        run_op(8, 16'h0000, 16'h0001, 1'b0, 0, r, bo, of);
        check("d00_01", 32'({of, bo, r}), 32'h1_00FF);
        run_op(8, 16'h0080, 16'h0001, 1'b0, 1, r, bo, of);
        check("d80_01", 32'({of, bo, r}), 32'h2_007F);
        run_op(8, 16'h0010, 16'h000F, 1'b1, 0, r, bo, of);
        check("d10_0F_b", 32'({of, bo, r}), 32'h0_0000);
        run_op(16, 16'h1234, 16'h4321, 1'b0, 2, r, bo, of);
        check("d1234_4321", 32'({of, bo, r}), 32'h1_CF13);

        // Asynchronous reset in the middle of a 16-bit operation.
        cur_w = 16;
        a_in = 16'hFFFF; b_in = 16'h0001; v16 = 1'b1;
        @(posedge clk); #1 v16 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(ov16), 32'd0);
        check("midrst_res", 32'(res16), 32'd0);
        check("midrst_ready", 32'(r16), 32'd0);
        check("midrst_res8", 32'(res8), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(16, 16'h8000, 16'h0001, 1'b0, 0, r, bo, of);
        check("after_rst", 32'({of, bo, r}), 32'h2_7FFF);

        for (int i = 0; i < 40; i++) begin
            run_op((i % 2 == 0) ? 8 : 16, 16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), r, bo, of);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

endmodule
